writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage of the 3-stage core; sits directly upstream of the register file and drives its write port.
//   Captures the retiring instruction from execute, waits on data memory for loads, aligns and extends load data, and selects the writeback value.
//   Stalls upstream while a load is outstanding. Outputs are stable for a full cycle so the register file's negedge write samples settled values.
// PARAMETERS
//   LOAD_TIMEOUT  16  max cycles in LOAD_WAIT before abort; must be >= 1; counter width $clog2(LOAD_TIMEOUT+1)
// PORTS
//   clk               in   1   core clock; all state updates on posedge
//   rst               in   1   asynchronous, active-high reset
//   ex_valid          in   1   execute presents a retiring instruction this cycle
//   ex_is_load        in   1   instruction is a load; result comes from mem_rdata
//   ex_reg_wr         in   1   instruction writes rd
//   ex_wb_sel         in   1   non-load result select: 0 = ex_alu_result, 1 = ex_pc + 4
//   ex_funct3         in   3   load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   ex_rd             in   5   destination register
//   ex_alu_result     in   32  ALU result / load effective address
//   ex_pc             in   32  instruction PC
//   mem_rvalid        in   1   load data valid (single-cycle pulse)
//   mem_rdata         in   32  raw 32-bit word from data memory
//   stall             out  1   hold execute and fetch; ex_* ignored while high
//   write_enable      out  1   register file write enable
//   write_address     out  5   register file write address
//   write_data        out  32  register file write data
//   load_timeout_err  out  1   sticky: a load exceeded LOAD_TIMEOUT
//   instret           out  64  retired-instruction count (only with WB_INSTRET_EN)
// BEHAVIOUR
//   - Reset: state IDLE; stall, write_enable, load_timeout_err = 0; write_address, write_data, instret, timeout counter = 0.
//   - Reset asserted mid-LOAD_WAIT abandons the load; no write occurs. A later mem_rvalid pulse in IDLE/WRITE is ignored.
//   - States: IDLE, LOAD_WAIT, WRITE. Accept = ex_valid && state != LOAD_WAIT.
//   - IDLE/WRITE: accept & ex_is_load -> LOAD_WAIT (latch rd, reg_wr, funct3, addr[1:0], clear counter).
//     accept & !ex_is_load -> WRITE (latch rd, reg_wr, data = wb_sel ? ex_pc+4 : ex_alu_result). No ex_valid -> IDLE.
//   - LOAD_WAIT: stall = 1 (combinational from state). On mem_rvalid -> WRITE with aligned data; counter increments otherwise.
//     Counter reaching LOAD_TIMEOUT without mem_rvalid -> IDLE, load_timeout_err <= 1 (sticky until rst), no write.
//     mem_rvalid in the same cycle the counter hits LOAD_TIMEOUT: data wins, go to WRITE, no error.
//   - WRITE: write_enable = reg_wr && rd != 0; write_address/write_data = latched values; held for exactly one cycle.
//     New instruction may be accepted in the same cycle (back-to-back non-loads retire one per cycle, latency 1).
//   - stall = 0 in IDLE and WRITE; load-to-write latency = 1 cycle after mem_rvalid.
//   - Load alignment (off = addr[1:0]): LB/LBU byte mem_rdata[8*off+:8]; LH/LHU half mem_rdata[16*off[1]+:16] (off[0] ignored);
//     LW whole word (offset ignored). LB/LH sign-extend, LBU/LHU zero-extend. Any other funct3 behaves as LW.
//   - ex_pc + 4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//   - rd == 0 or reg_wr == 0: instruction still passes through WRITE (counted), write_enable stays 0.
//   - write_address/write_data hold last value when write_enable is 0.
// CONFIGURATION
//   WB_INSTRET_EN defined: instret port present; increments by 1 on every cycle in WRITE (including no-write instructions), wraps at 2^64; not incremented on timeout abort.
//   WB_INSTRET_EN undefined: instret port and counter absent; all other behaviour identical.
// TESTING
//   1. rst pulse mid-cycle -> all outputs 0 immediately, state IDLE; release, no ex_valid -> write_enable stays 0.
//   2. ALU op rd=5, alu=0x1234, wb_sel=0 -> next cycle write_enable=1, addr=5, data=0x00001234; rd=0 variant -> write_enable=0.
//   3. JAL rd=1, pc=0xFFFFFFFC, wb_sel=1 -> data=0x00000000; back-to-back 3 ALU ops -> 3 consecutive write cycles, stall=0.
//   4. LB addr[1:0]=3, mem_rdata=0x80FF1234 after 2-cycle wait -> stall high 2 cycles, data=0xFFFFFF80; LHU addr=2 -> 0x000080FF.
//   5. Load with no mem_rvalid, LOAD_TIMEOUT=16 -> stall high 16 cycles, then IDLE, load_timeout_err=1, no write; stays 1 until rst.
//   6. WB_INSTRET_EN: 10 retirements incl. one rd=0 and one timed-out load -> instret=9; rebuild without macro -> port absent, tests 1-5 pass.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - retire stage: load wait, load alignment, register file write port
// Optional feature macro: WB_INSTRET_EN adds the 64-bit retired-instruction counter and instret port.
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_reg_wr,
  input  logic        ex_wb_sel,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
`ifdef WB_INSTRET_EN
  output logic [63:0] instret,
`endif
  output logic        load_timeout_err
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(LOAD_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_WRITE     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic          ld_reg_wr_q, ld_reg_wr_d;
  logic [2:0]    ld_funct3_q, ld_funct3_d;
  logic [1:0]    ld_off_q, ld_off_d;

  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   pc_plus4;
  logic [31:0]   load_value;

  // Byte/half selection from the raw word; unknown funct3 values fall back to a full word.
  function automatic logic [31:0] align_load(input logic [2:0] funct3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b100:  align_load = {24'd0, b};
      3'b101:  align_load = {16'd0, h};
      default: align_load = rdata;
    endcase
  endfunction

  assign accept     = ex_valid && (state_q != S_LOAD_WAIT);
  assign cnt_inc    = cnt_q + CW'(1);
  assign pc_plus4   = ex_pc + 32'd4;
  assign load_value = align_load(ld_funct3_q, ld_off_q, mem_rdata);

  // Next-state and next-output computation for the retire FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ld_rd_d     = ld_rd_q;
    ld_reg_wr_d = ld_reg_wr_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    case (state_q)
      S_LOAD_WAIT: begin
        if (mem_rvalid) begin
          // Data arriving on the final allowed cycle still completes the load.
          state_d = S_WRITE;
          if (ld_reg_wr_q && (ld_rd_q != 5'd0)) begin
            we_d   = 1'b1;
            addr_d = ld_rd_q;
            data_d = load_value;
          end
        end else if (cnt_inc == TIMEOUT_VAL) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        if (accept) begin
          if (ex_is_load) begin
            state_d     = S_LOAD_WAIT;
            cnt_d       = '0;
            ld_rd_d     = ex_rd;
            ld_reg_wr_d = ex_reg_wr;
            ld_funct3_d = ex_funct3;
            ld_off_d    = ex_alu_result[1:0];
          end else begin
            state_d = S_WRITE;
            if (ex_reg_wr && (ex_rd != 5'd0)) begin
              we_d   = 1'b1;
              addr_d = ex_rd;
              data_d = ex_wb_sel ? pc_plus4 : ex_alu_result;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Retire FSM state and registered register-file outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= 32'd0;
      ld_rd_q     <= 5'd0;
      ld_reg_wr_q <= 1'b0;
      ld_funct3_q <= 3'd0;
      ld_off_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ld_rd_q     <= ld_rd_d;
      ld_reg_wr_q <= ld_reg_wr_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Every cycle spent in WRITE is one retired instruction, including ones that do not write rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else if (state_q == S_WRITE) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

  assign stall            = (state_q == S_LOAD_WAIT);
  assign write_enable     = we_q;
  assign write_address    = addr_q;
  assign write_data       = data_q;
  assign load_timeout_err = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed scoreboard bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_reg_wr, ex_wb_sel;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall, write_enable, load_timeout_err;
  logic [4:0]  write_address;
  logic [31:0] write_data;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;
  int ret_exp = 0;
  logic [36:0] sb[$];

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;
  ld_vec_t lv[9];

  always #5 clk = ~clk;

  writeback_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result), .ex_pc(ex_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data),
`ifdef WB_INSTRET_EN
    .instret(instret),
`endif
    .load_timeout_err(load_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    logic [36:0] e;
    if (write_enable === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=write rd%0d data=%0h expected=no write", write_address, write_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_addr", 64'(write_address), 64'(e[36:32]));
        chk("sb_data", 64'(write_data), 64'(e[31:0]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sb_check();
  endtask

  task automatic retire(input logic wr, input logic [4:0] a, input logic [31:0] d);
    ret_exp++;
    if (wr) sb.push_back({a, d});
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_reg_wr = 1'b0; ex_wb_sel = 1'b0;
    ex_funct3 = 3'd0; ex_rd = 5'd0; ex_alu_result = 32'd0; ex_pc = 32'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic wr, input logic sel,
                           input logic [31:0] alu, input logic [31:0] pc);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_reg_wr = wr; ex_wb_sel = sel;
    ex_funct3 = 3'd0; ex_rd = rd; ex_alu_result = alu; ex_pc = pc;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_wb_sel = 1'b0;
    ex_funct3 = f3; ex_rd = rd; ex_alu_result = addr; ex_pc = 32'h200;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    lv[0] = '{3'b000, 2'd2, 32'hFFFFFFFF};
    lv[1] = '{3'b100, 2'd2, 32'h000000FF};
    lv[2] = '{3'b100, 2'd1, 32'h00000012};
    lv[3] = '{3'b001, 2'd2, 32'hFFFF80FF};
    lv[4] = '{3'b001, 2'd1, 32'h00001234};
    lv[5] = '{3'b101, 2'd2, 32'h000080FF};
    lv[6] = '{3'b101, 2'd3, 32'h000080FF};
    lv[7] = '{3'b010, 2'd1, 32'h80FF1234};
    lv[8] = '{3'b011, 2'd2, 32'h80FF1234};

    rst = 1'b1; idle(); mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_addr", 64'(write_address), 64'd0);
    chk("rst_data", 64'(write_data), 64'd0);
    chk("rst_err", 64'(load_timeout_err), 64'd0);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_we", 64'(write_enable), 64'd0);

    // ALU op, rd=0 and reg_wr=0 variants
    drive_alu(5'd5, 1'b1, 1'b0, 32'h1234, 32'h100); retire(1'b1, 5'd5, 32'h1234);
    tick();
    chk("alu_we", 64'(write_enable), 64'd1);
    chk("alu_data", 64'(write_data), 64'h1234);
    drive_alu(5'd0, 1'b1, 1'b0, 32'h5555, 32'h104); retire(1'b0, 5'd0, 32'd0);
    tick();
    chk("rd0_we", 64'(write_enable), 64'd0);
    drive_alu(5'd6, 1'b0, 1'b0, 32'h7777, 32'h108); retire(1'b0, 5'd0, 32'd0);
    tick();
    chk("nowr_we", 64'(write_enable), 64'd0);
    idle();
    tick();
    chk("hold_we", 64'(write_enable), 64'd0);
    chk("hold_addr", 64'(write_address), 64'd5);
    chk("hold_data", 64'(write_data), 64'h1234);

    // JAL with PC wrap, then back-to-back ALU ops
    drive_alu(5'd1, 1'b1, 1'b1, 32'hDEAD, 32'hFFFFFFFC); retire(1'b1, 5'd1, 32'h0);
    tick();
    chk("jal_data", 64'(write_data), 64'h0);
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(10 + i), 1'b1, 1'b0, 32'hA0 + 32'(i), 32'h300);
      retire(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      tick();
      chk("b2b_we", 64'(write_enable), 64'd1);
      chk("b2b_stall", 64'(stall), 64'd0);
    end
    idle();
    tick();
    chk("b2b_end_we", 64'(write_enable), 64'd0);

    // LB offset 3 after a two-cycle wait; ex_* offered during the wait must be ignored
    drive_load(5'd7, 3'b000, 32'h1003);
    tick();
    chk("lb_wait1", 64'(stall), 64'd1);
    drive_alu(5'd20, 1'b1, 1'b0, 32'hBAD, 32'h0);
    tick();
    chk("lb_wait2", 64'(stall), 64'd1);
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF1234; retire(1'b1, 5'd7, 32'hFFFFFF80);
    tick();
    mem_rvalid = 1'b0;
    chk("lb_we", 64'(write_enable), 64'd1);
    chk("lb_stall", 64'(stall), 64'd0);
    tick();
    chk("lb_ignored_we", 64'(write_enable), 64'd0);

    // Alignment table, one-cycle wait each
    for (int i = 0; i < 9; i++) begin
      drive_load(5'd3, lv[i].f3, {30'h40, lv[i].off});
      tick();
      idle();
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF1234; retire(1'b1, 5'd3, lv[i].exp);
      tick();
      mem_rvalid = 1'b0;
      chk("align_we", 64'(write_enable), 64'd1);
    end

    // Data arriving on the 16th wait cycle wins over the timeout
    drive_load(5'd4, 3'b010, 32'h0);
    tick();
    idle();
    repeat (15) tick();
    chk("edge_stall", 64'(stall), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; retire(1'b1, 5'd4, 32'hCAFEF00D);
    tick();
    mem_rvalid = 1'b0;
    chk("edge_we", 64'(write_enable), 64'd1);
    chk("edge_err", 64'(load_timeout_err), 64'd0);

    // Timeout: 16 stall cycles, sticky error, no write, stray rvalid ignored
    drive_load(5'd9, 3'b000, 32'h0);
    tick();
    idle();
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_stall_cycles", 64'(n), 64'd16);
    chk("to_err", 64'(load_timeout_err), 64'd1);
    chk("to_we", 64'(write_enable), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_rvalid = 1'b0;
    chk("to_stray_we", 64'(write_enable), 64'd0);
    tick();
    chk("to_sticky", 64'(load_timeout_err), 64'd1);
`ifdef WB_INSTRET_EN
    chk("instret", instret, 64'(ret_exp));
`endif

    // Mid-cycle reset while a write is on the port
    drive_alu(5'd5, 1'b1, 1'b0, 32'h99, 32'h0); retire(1'b1, 5'd5, 32'h99);
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("mrst_we", 64'(write_enable), 64'd0);
    chk("mrst_addr", 64'(write_address), 64'd0);
    chk("mrst_data", 64'(write_data), 64'd0);
    chk("mrst_err", 64'(load_timeout_err), 64'd0);
    chk("mrst_stall", 64'(stall), 64'd0);
`ifdef WB_INSTRET_EN
    chk("mrst_instret", instret, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mrst_idle_we", 64'(write_enable), 64'd0);

    // Reset during LOAD_WAIT abandons the load; later rvalid is ignored
    drive_load(5'd11, 3'b010, 32'h0);
    tick();
    idle();
    chk("abandon_stall", 64'(stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abandon_rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_rvalid = 1'b0;
    chk("abandon_we", 64'(write_enable), 64'd0);
    tick();
    chk("abandon_we2", 64'(write_enable), 64'd0);

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
